hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_mdu_timer.sv | 28 ++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        ST_RUN,
        ST_MDU_WAIT
    } state_e;

    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         MDU_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/hazard_mdu_timer.sv
// Down-counter for the multi-cycle mult/div wait; done flags a count of zero.
module hazard_mdu_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // Decrement is gated by done so the count can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (en && !done) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and optional mult/div wait control for the ID stage.
// Macro HAZARD_MDU_STALL_EN enables the MDU_WAIT state and its timer.
//
// state        | meaning
// ST_RUN       | normal decode of load-use / mdu-start / branch-taken
// ST_MDU_WAIT  | pipeline frozen while the multi-cycle mult/div completes
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic       id_branch_taken,
    input  logic       id_mdu_start,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       mdu_busy
);

    logic load_use;
    logic in_wait;
    logic mdu_go;

    assign load_use = ex_is_load && (ex_rd != REG_ZERO) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

`ifdef HAZARD_MDU_STALL_EN
    localparam int             CW       = $clog2(MDU_CYCLES + 1);
    localparam logic [CW-1:0]  LOAD_VAL = CW'(MDU_CYCLES - 1);

    state_e state_q, state_d;
    logic   tmr_load;
    logic   tmr_en;
    logic   tmr_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mdu_go) begin
                    tmr_load = 1'b1;
                    state_d  = ST_MDU_WAIT;
                end
            end
            ST_MDU_WAIT: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    hazard_mdu_timer #(
        .W (CW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .en    (tmr_en),
        .value (LOAD_VAL),
        .done  (tmr_done)
    );

    assign in_wait = (state_q == ST_MDU_WAIT);
    assign mdu_go  = !load_use && id_mdu_start;
`else
    // Purely combinational build: clock, reset and mdu start have no effect.
    logic unused_sig;
    assign unused_sig = ^{clk, rst, id_mdu_start, 8'(MDU_CYCLES)};
    assign in_wait    = 1'b0;
    assign mdu_go     = 1'b0;
`endif

    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mdu_busy   = 1'b0;
        if (in_wait) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            mdu_busy   = 1'b1;
        end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end else if (!mdu_go) begin
            ifid_flush = id_branch_taken;
        end
    end

endmodule
